serial_full_adder: RTL and testbench

Bit-serial N-bit adder that sits directly upstream of the single-bit dataflow full adder and drives it one bit position per clock. It accepts two WIDTH-bit operands and a carry-in on a start pulse. It feeds one bit of each operand plus the stored carry through the full-adder equations each cycle and accumulates the sum LSB-first. It presents the WIDTH-bit result and carry-out with a one-cycle done pulse, trading WIDTH cycles of latency for a single full-adder cell.

---
 rtl/serial_full_adder.sv | 148 ++++++++++++++
 tb/tb_serial_full_adder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_full_adder.sv
// ---------------------------------------------------------------------------
// serial_full_adder
//
// Bit-serial adder: computes {Carry, Sum} = a + b + c using one full-adder
// cell, processing one bit position per clock, LSB first.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request; accepted in IDLE or DONE, ignored while busy
//   a, b   WIDTH-bit operands, captured on an accepted start
//   c      carry-in, captured on an accepted start
//   busy   high while the addition is in progress
//   done   one-cycle pulse; Sum/Carry have just been updated
//   Sum    registered WIDTH-bit result, held until the next completion
//   Carry  registered carry-out of the MSB, held alongside Sum
//
// Latency: start sampled at edge E0 -> done visible after edge E0+WIDTH.
// ---------------------------------------------------------------------------
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             cf;
    // The partial sum only keeps bits [WIDTH-1:1]: the bit that would land in
    // position 0 is consumed by Sum on the very edge it would be shifted in,
    // so storing it would leave a flop nobody reads.
    logic [WIDTH-1:1] ps;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             cf_nxt;
    logic [WIDTH-1:0] ps_full;   // {s, ps} : the partial sum after this bit
    logic             load;

    // ------------------------------------------------------------------
    // Next-state, outputs and the single full-adder cell
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;

        s_bit   = sa[0] ^ sb[0] ^ cf;
        cf_nxt  = (sa[0] & sb[0]) | (sb[0] & cf) | (sa[0] & cf);
        ps_full = {s_bit, ps};

        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ADD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // NOTE: all datapath flops, including the result registers, are cleared
    // by reset so an aborted addition leaves no stale Sum/Carry behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            cf    <= 1'b0;
            ps    <= '0;
            cnt   <= '0;
            Sum   <= '0;
            Carry <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            cf  <= c;
            ps  <= '0;
            cnt <= '0;
        end else if (state == ADD) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            cf  <= cf_nxt;
            ps  <= ps_full[WIDTH-1:1];
            cnt <= cnt + CW'(1);
            // Final bit: publish the completed result on the same edge.
            if (cnt == LAST) begin
                Sum   <= ps_full;
                Carry <= cf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_full_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_full_adder
//
// Runs an 8-bit and a 16-bit serial_full_adder side by side on shared
// stimulus. A transaction-level model (accepted start -> result a+b+c due
// WIDTH edges later) predicts busy, done, Sum and Carry for every cycle;
// directed sequences add literal expectations for specific cases.
// ---------------------------------------------------------------------------
module tb_serial_full_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        c = 1'b0;

    logic        busy8, done8, carry8;
    logic [7:0]  sum8;
    logic        busy16, done16, carry16;
    logic [15:0] sum16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start),
        .a(a[7:0]), .b(b[7:0]), .c(c),
        .busy(busy8), .done(done8), .Sum(sum8), .Carry(carry8)
    );

    serial_full_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start),
        .a(a[15:0]), .b(b[15:0]), .c(c),
        .busy(busy16), .done(done16), .Sum(sum16), .Carry(carry16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one in-flight transaction per adder
    // ------------------------------------------------------------------
    int          cyc = 0;
    int          due     [2] = '{-1, -1};   // edge number when result lands
    logic [63:0] pend    [2];               // a+b+c of the in-flight op
    logic [63:0] m_sum   [2] = '{0, 0};
    logic        m_carry [2] = '{0, 0};
    logic        m_done  [2] = '{0, 0};
    int          n_done  [2] = '{0, 0};
    bit          chk_en = 1'b0;

    function automatic int width_of(input int k);
        return (k == 0) ? 8 : 16;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [63:0] msk;
            msk = (64'd1 << width_of(k)) - 64'd1;
            if (rst) begin
                due[k]     = -1;
                m_sum[k]   = '0;
                m_carry[k] = 1'b0;
                m_done[k]  = 1'b0;
            end else begin
                m_done[k] = 1'b0;
                if (due[k] == cyc) begin
                    m_sum[k]   = pend[k] & msk;
                    m_carry[k] = pend[k][width_of(k)];
                    m_done[k]  = 1'b1;
                    due[k]     = -1;
                    n_done[k]++;
                end else if (start && due[k] < 0) begin
                    due[k]  = cyc + width_of(k);
                    pend[k] = ({32'd0, a} & msk) + ({32'd0, b} & msk) + {63'd0, c};
                end
            end
        end
        cyc++;
    end

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8",   {63'd0, busy8},   {63'd0, due[0] >= 0});
            check("done8",   {63'd0, done8},   {63'd0, m_done[0]});
            check("sum8",    {56'd0, sum8},    m_sum[0]);
            check("carry8",  {63'd0, carry8},  {63'd0, m_carry[0]});
            check("busy16",  {63'd0, busy16},  {63'd0, due[1] >= 0});
            check("done16",  {63'd0, done16},  {63'd0, m_done[1]});
            check("sum16",   {48'd0, sum16},   m_sum[1]);
            check("carry16", {63'd0, carry16}, {63'd0, m_carry[1]});
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (8-bit adder)
    // ------------------------------------------------------------------
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_in, input logic tc,
                       input logic [8:0] exp_res, input string name);
        int n;
        @(negedge clk);
        a = {24'd0, ta}; b = {24'd0, tb_in}; c = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 64'(n), 64'd9);
        check({name, " result"},  {55'd0, carry8, sum8}, {55'd0, exp_res});
        check({name, " model"},   {55'd0, m_carry[0], m_sum[0][7:0]}, {55'd0, exp_res});
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int pulses;
        int gap;
        int budget;

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset busy8", {63'd0, busy8}, 64'd0);
        check("reset sum8",  {55'd0, carry8, sum8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic additions
        op8(8'h5A, 8'h3C, 1'b0, 9'h096, "5A+3C");
        op8(8'hFF, 8'h01, 1'b0, 9'h100, "FF+01");
        op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "FF+FF+1");
        op8(8'h00, 8'h00, 1'b1, 9'h001, "00+00+1");

        // start during ADD is ignored
        wait_cycles(20);
        @(negedge clk);
        a = 32'h12; b = 32'h34; c = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cycles(2);
        a = 32'hFF; b = 32'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (done8) begin
                pulses++;
                check("overlap result", {55'd0, carry8, sum8}, 64'h046);
            end
            @(negedge clk);
        end
        check("overlap done count", 64'(pulses), 64'd1);

        // Reset in the middle of an addition
        wait_cycles(20);
        a = 32'h80; b = 32'h80; c = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cycles(4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy8", {63'd0, busy8}, 64'd0);
        check("abort sum8",  {55'd0, carry8, sum8}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8) pulses++;
            @(negedge clk);
        end
        check("abort no done", 64'(pulses), 64'd0);
        op8(8'h01, 8'h02, 1'b0, 9'h003, "after abort");

        // Back-to-back with start held high
        wait_cycles(20);
        a = 32'h10; b = 32'h20; c = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 32'hF0;
        gap = 1;
        while (!done8 && gap < 20) begin @(negedge clk); gap++; end
        check("b2b first latency", 64'(gap), 64'd9);
        check("b2b first result", {55'd0, carry8, sum8}, 64'h030);
        @(negedge clk);
        gap = 1;
        while (!done8 && gap < 20) begin @(negedge clk); gap++; end
        start = 1'b0;
        check("b2b period", 64'(gap), 64'd9);
        check("b2b second result", {55'd0, carry8, sum8}, 64'h110);
        wait_cycles(20);

        // Randomised: at least 1000 completions on each width
        budget = 0;
        n_done[0] = 0;
        n_done[1] = 0;
        while ((n_done[0] < 1000 || n_done[1] < 1000) && budget < 40000) begin
            @(negedge clk);
            a     = $urandom;
            b     = $urandom;
            c     = 1'($urandom);
            start = ($urandom_range(3, 0) != 0);
            rst   = ($urandom_range(499, 0) == 0);
            budget++;
        end
        start = 1'b0;
        rst   = 1'b0;
        check("random completions8",  64'(n_done[0] >= 1000), 64'd1);
        check("random completions16", 64'(n_done[1] >= 1000), 64'd1);
        wait_cycles(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
